bus_arb2: RTL and testbench

BUS_ARB2 -- requirements
Module: bus_arb2

---
 rtl/bus_arb2_pkg.sv | 20 ++
 rtl/bus_arb2_if.sv | 15 +
 rtl/bus_watchdog.sv | 25 ++
 rtl/bus_arb2.sv | 92 +++++++++
 tb/tb_bus_arb2.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb2_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// default watchdog limit, abort read data and the grant decision.
package bus_arb2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam logic [31:0] ABORT_RDATA     = 32'h0000_0000;

    // Returns 1 when m1 should be granted. m1 wins when m0 is not asking, or when
    // both ask under round-robin and m0 was the last master served.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last, input logic fixed_prio);
        return req1 && (!req0 || (!fixed_prio && !last));
    endfunction

endpackage

// File: rtl/bus_arb2_if.sv
// Simple valid/ready request bus used on both the master and the slave side
// of the arbiter.
interface bus_arb2_if;

    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/bus_watchdog.sv
// Busy-cycle watchdog: flags the cycle in which the running transfer has been
// busy for exactly 'limit' cycles.
module bus_watchdog (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    // count holds completed busy cycles, so the live watchdog value is count + 1
    // (1 on the first busy cycle, 0 whenever run is low).
    always_ff @(posedge clk_24) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 16'd1;
        end
    end

    assign expired = run && ((count + 16'd1) == limit);

endmodule

// File: rtl/bus_arb2.sv
// Two-master arbiter onto one shared slave bus, with round-robin or fixed
// priority and a watchdog that aborts stalled transfers.
module bus_arb2
    import bus_arb2_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic       clk_24,
    input  logic       reset,
    bus_arb2_if.slave  m0,
    bus_arb2_if.slave  m1,
    bus_arb2_if.master s,
    output logic       owner,
    output logic       err,
    output logic       err_id,
    input  logic       err_clr
);

    arb_state_t  state;
    logic        own_q;
    logic        last;
    logic        busy;
    logic        own_valid;
    logic        live;
    logic        expired;
    logic        respond;
    logic        abort;
    logic [31:0] rdata;

    assign busy      = (state == BUSY);
    assign own_valid = own_q ? m1.valid : m0.valid;
    assign live      = busy && own_valid;
    assign abort     = live && expired && !s.ready;
    assign respond   = live && (s.ready || expired);

    bus_watchdog u_watchdog (
        .clk_24 (clk_24),
        .reset  (reset),
        .run    (busy),
        .limit  (16'(TIMEOUT)),
        .expired(expired)
    );

    always_ff @(posedge clk_24) begin
        if (reset) begin
            state  <= IDLE;
            own_q  <= 1'b0;
            last   <= 1'b1;
            err    <= 1'b0;
            err_id <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.valid || m1.valid) begin
                        own_q <= pick_winner(m0.valid, m1.valid, last, PRIO_MODE != 0);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A withdrawn request leaves without touching the pointer.
                    if (!own_valid || respond) begin
                        state <= IDLE;
                    end
                    if (respond) begin
                        last <= own_q;
                    end
                end
            endcase
            if (abort) begin
                err    <= 1'b1;
                err_id <= own_q;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign owner = busy && own_q;

    assign s.valid = busy;
    assign s.addr  = busy ? (own_q ? m1.addr  : m0.addr)  : '0;
    assign s.wdata = busy ? (own_q ? m1.wdata : m0.wdata) : '0;
    assign s.wstrb = busy ? (own_q ? m1.wstrb : m0.wstrb) : '0;

    assign rdata    = abort ? ABORT_RDATA : (busy ? s.rdata : '0);
    assign m0.ready = respond && !own_q;
    assign m1.ready = respond && own_q;
    assign m0.rdata = rdata;
    assign m1.rdata = rdata;

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: directed cycle table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_bus_arb2;

    localparam int unsigned TO = 4;
    localparam logic [31:0] A0 = 32'h1000_0004;
    localparam logic [31:0] D0 = 32'h0BAD_F00D;
    localparam logic [31:0] A1 = 32'h2000_0000;
    localparam logic [31:0] D1 = 32'hAABB_CCDD;

    logic clk_24 = 1'b0;
    logic rst;
    logic err_clr;
    logic owner, err, err_id;
    logic f_clr;
    logic f_owner, f_err, f_err_id;

    bus_arb2_if m0_if ();
    bus_arb2_if m1_if ();
    bus_arb2_if s_if ();
    bus_arb2_if fm0_if ();
    bus_arb2_if fm1_if ();
    bus_arb2_if fs_if ();

    bus_arb2 #(.PRIO_MODE(0), .TIMEOUT(TO)) dut (
        .clk_24(clk_24), .reset(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
        .owner(owner), .err(err), .err_id(err_id), .err_clr(err_clr)
    );

    bus_arb2 #(.PRIO_MODE(1), .TIMEOUT(TO)) dut_fp (
        .clk_24(clk_24), .reset(rst), .m0(fm0_if), .m1(fm1_if), .s(fs_if),
        .owner(f_owner), .err(f_err), .err_id(f_err_id), .err_clr(f_clr)
    );

    always #21 clk_24 = ~clk_24;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // in = {v0, v1, s_ready, err_clr}; ex = {s_valid, owner, m0_ready, m1_ready, err, err_id}
    typedef struct {
        logic [3:0]  in;
        logic [3:0]  w1;
        logic [31:0] srd;
        logic [5:0]  ex;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [26];

    task automatic drv(input logic v0, input logic v1, input logic [3:0] w1,
                       input logic sr, input logic [31:0] srd, input logic clr);
        m0_if.valid = v0; m0_if.addr = A0; m0_if.wdata = D0; m0_if.wstrb = 4'h0;
        m1_if.valid = v1; m1_if.addr = A1; m1_if.wdata = D1; m1_if.wstrb = w1;
        s_if.ready = sr; s_if.rdata = srd; err_clr = clr;
    endtask

    task automatic nxt();
        @(posedge clk_24);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Fixed-priority instance: both masters always requesting, slave always ready.
    initial begin
        f_clr = 1'b0;
        fm0_if.valid = 1'b1; fm0_if.addr = A0; fm0_if.wdata = D0; fm0_if.wstrb = 4'h0;
        fm1_if.valid = 1'b1; fm1_if.addr = A1; fm1_if.wdata = D1; fm1_if.wstrb = 4'h0;
        fs_if.ready = 1'b1; fs_if.rdata = 32'h0;
    end

    initial begin
        #(42 * 50000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int q_rr[$];
    int q_fp[$];
    logic fp_m1_ready;
    logic        pend[2];
    logic [31:0] ta[2], td[2];
    logic [3:0]  tw[2];
    logic        mbusy, merr, meid, clr_r, done, abt;
    int          cur, bc, lat, last;
    logic [31:0] srd_r;

    initial begin
        tbl[0]  = '{4'b0000, 4'h0, 32'h0,         6'b000000, 32'h0};
        tbl[1]  = '{4'b1000, 4'h0, 32'h0,         6'b000000, 32'h0};
        tbl[2]  = '{4'b1000, 4'h0, 32'h0,         6'b100000, 32'h0};
        tbl[3]  = '{4'b1010, 4'h0, 32'h1234_5678, 6'b101000, 32'h1234_5678};
        tbl[4]  = '{4'b0000, 4'h0, 32'h0,         6'b000000, 32'h0};
        tbl[5]  = '{4'b0100, 4'h3, 32'h0,         6'b000000, 32'h0};
        tbl[6]  = '{4'b0100, 4'h3, 32'h0,         6'b110000, 32'h0};
        tbl[7]  = '{4'b0110, 4'h3, 32'h0,         6'b110100, 32'h0};
        tbl[8]  = '{4'b0000, 4'h0, 32'h0,         6'b000000, 32'h0};
        tbl[9]  = '{4'b0100, 4'h0, 32'h0,         6'b000000, 32'h0};
        tbl[10] = '{4'b0100, 4'h0, 32'hDEAD_BEEF, 6'b110000, 32'hDEAD_BEEF};
        tbl[11] = '{4'b0100, 4'h0, 32'hDEAD_BEEF, 6'b110000, 32'hDEAD_BEEF};
        tbl[12] = '{4'b0100, 4'h0, 32'hDEAD_BEEF, 6'b110000, 32'hDEAD_BEEF};
        tbl[13] = '{4'b0100, 4'h0, 32'hDEAD_BEEF, 6'b110100, 32'h0};
        tbl[14] = '{4'b0000, 4'h0, 32'h0,         6'b000011, 32'h0};
        tbl[15] = '{4'b0001, 4'h0, 32'h0,         6'b000011, 32'h0};
        tbl[16] = '{4'b0000, 4'h0, 32'h0,         6'b000001, 32'h0};
        tbl[17] = '{4'b1000, 4'h0, 32'h0,         6'b000001, 32'h0};
        tbl[18] = '{4'b1000, 4'h0, 32'h0,         6'b100001, 32'h0};
        tbl[19] = '{4'b0010, 4'h0, 32'h0,         6'b100001, 32'h0};
        tbl[20] = '{4'b0000, 4'h0, 32'h0,         6'b000001, 32'h0};
        tbl[21] = '{4'b1100, 4'h0, 32'h0,         6'b000001, 32'h0};
        tbl[22] = '{4'b1110, 4'h0, 32'h0,         6'b101001, 32'h0};
        tbl[23] = '{4'b1100, 4'h0, 32'h0,         6'b000001, 32'h0};
        tbl[24] = '{4'b1110, 4'h0, 32'h55AA_55AA, 6'b110101, 32'h55AA_55AA};
        tbl[25] = '{4'b0000, 4'h0, 32'h0,         6'b000001, 32'h0};

        do_reset();

        // Directed cycle table: m0 read, m1 write, m1 timeout/clear, withdrawn request, RR pair.
        for (int i = 0; i < 26; i++) begin
            drv(tbl[i].in[3], tbl[i].in[2], tbl[i].w1, tbl[i].in[1], tbl[i].srd, tbl[i].in[0]);
            @(negedge clk_24);
            chk($sformatf("t%0d s_valid", i), 32'(s_if.valid), 32'(tbl[i].ex[5]));
            chk($sformatf("t%0d owner", i), 32'(owner), 32'(tbl[i].ex[4]));
            chk($sformatf("t%0d m0_ready", i), 32'(m0_if.ready), 32'(tbl[i].ex[3]));
            chk($sformatf("t%0d m1_ready", i), 32'(m1_if.ready), 32'(tbl[i].ex[2]));
            chk($sformatf("t%0d err", i), 32'(err), 32'(tbl[i].ex[1]));
            chk($sformatf("t%0d err_id", i), 32'(err_id), 32'(tbl[i].ex[0]));
            chk($sformatf("t%0d s_wstrb", i), 32'(s_if.wstrb),
                32'((tbl[i].ex[5] && tbl[i].ex[4]) ? tbl[i].w1 : 4'h0));
            chk($sformatf("t%0d m0_rdata", i), m0_if.rdata, tbl[i].rd);
            chk($sformatf("t%0d m1_rdata", i), m1_if.rdata, tbl[i].rd);
            if (tbl[i].ex[5]) begin
                chk($sformatf("t%0d s_addr", i), s_if.addr, tbl[i].ex[4] ? A1 : A0);
                chk($sformatf("t%0d s_wdata", i), s_if.wdata, tbl[i].ex[4] ? D1 : D0);
            end
            nxt();
        end

        // Both masters held from reset: round-robin alternates, fixed priority starves m1.
        do_reset();
        drv(1'b1, 1'b1, 4'h0, 1'b1, 32'h0, 1'b0);
        fp_m1_ready = 1'b0;
        for (int c = 0; c < 40 && (q_rr.size() < 4 || q_fp.size() < 4); c++) begin
            @(negedge clk_24);
            if (s_if.valid) q_rr.push_back(int'(owner));
            if (fs_if.valid) q_fp.push_back(int'(f_owner));
            if (fm1_if.ready) fp_m1_ready = 1'b1;
            nxt();
        end
        chk("rr_grant_count", 32'(q_rr.size() >= 4), 32'd1);
        chk("fp_grant_count", 32'(q_fp.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < q_rr.size()) chk($sformatf("rr_grant%0d", k), 32'(q_rr[k]), 32'(k % 2));
            if (k < q_fp.size()) chk($sformatf("fp_grant%0d", k), 32'(q_fp[k]), 32'd0);
        end
        chk("fp_m1_never_ready", 32'(fp_m1_ready), 32'd0);

        // m1 timeout, then m0 timeout coinciding with err_clr.
        do_reset();
        drv(1'b0, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0);
        nxt();
        for (int b = 1; b <= 3; b++) begin
            drv(1'b0, 1'b1, 4'h0, 1'b0, 32'h1111_2222, 1'b0);
            @(negedge clk_24);
            chk($sformatf("to1_bc%0d m1_ready", b), 32'(m1_if.ready), 32'd0);
            nxt();
        end
        @(negedge clk_24);
        chk("to1_abort m1_ready", 32'(m1_if.ready), 32'd1);
        chk("to1_abort m1_rdata", m1_if.rdata, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_24);
        chk("to1 err", 32'(err), 32'd1);
        chk("to1 err_id", 32'(err_id), 32'd1);
        nxt();
        for (int b = 1; b <= 3; b++) nxt();
        drv(1'b1, 1'b0, 4'h0, 1'b0, 32'h3333_4444, 1'b1);
        @(negedge clk_24);
        chk("to0_abort m0_ready", 32'(m0_if.ready), 32'd1);
        chk("to0_abort m0_rdata", m0_if.rdata, 32'h0);
        nxt();
        drv(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_24);
        chk("clr_vs_timeout err", 32'(err), 32'd1);
        chk("clr_vs_timeout err_id", 32'(err_id), 32'd0);
        nxt();

        // s_ready on the timeout cycle completes normally.
        drv(1'b0, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0);
        nxt();
        for (int b = 1; b <= 3; b++) nxt();
        drv(1'b0, 1'b1, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        @(negedge clk_24);
        chk("ready_at_limit m1_ready", 32'(m1_if.ready), 32'd1);
        chk("ready_at_limit m1_rdata", m1_if.rdata, 32'hCAFE_F00D);
        nxt();
        drv(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_24);
        chk("ready_at_limit err", 32'(err), 32'd1);
        chk("ready_at_limit err_id", 32'(err_id), 32'd0);
        nxt();

        // Reset in the second BUSY cycle, then a simultaneous request.
        drv(1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        nxt();
        nxt();
        rst = 1'b1;
        @(negedge clk_24);
        chk("pre_reset s_valid", 32'(s_if.valid), 32'd1);
        nxt();
        rst = 1'b0;
        drv(1'b1, 1'b1, 4'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_24);
        chk("post_reset s_valid", 32'(s_if.valid), 32'd0);
        chk("post_reset err", 32'(err), 32'd0);
        chk("post_reset err_id", 32'(err_id), 32'd0);
        chk("post_reset owner", 32'(owner), 32'd0);
        chk("post_reset m0_ready", 32'(m0_if.ready), 32'd0);
        nxt();
        drv(1'b1, 1'b1, 4'h0, 1'b1, 32'h0, 1'b0);
        @(negedge clk_24);
        chk("post_reset grant s_valid", 32'(s_if.valid), 32'd1);
        chk("post_reset grant owner", 32'(owner), 32'd0);
        chk("post_reset grant m0_ready", 32'(m0_if.ready), 32'd1);
        nxt();

        // Randomized traffic against a transaction-level model.
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        mbusy = 1'b0; merr = 1'b0; meid = 1'b0; last = 1; cur = 0; bc = 0; lat = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    ta[i] = $urandom;
                    td[i] = $urandom;
                    tw[i] = 4'($urandom);
                end
            end
            m0_if.valid = pend[0]; m0_if.addr = ta[0]; m0_if.wdata = td[0]; m0_if.wstrb = tw[0];
            m1_if.valid = pend[1]; m1_if.addr = ta[1]; m1_if.wdata = td[1]; m1_if.wstrb = tw[1];
            clr_r = ($urandom_range(7) == 0);
            err_clr = clr_r;
            if (mbusy) begin
                srd_r = $urandom;
                s_if.ready = (bc == lat);
            end else begin
                srd_r = 32'h0;
                s_if.ready = 1'($urandom_range(1));
            end
            s_if.rdata = srd_r;
            @(negedge clk_24);
            done = mbusy && (bc == lat);
            abt  = mbusy && !done && (bc == int'(TO));
            chk("rnd s_valid", 32'(s_if.valid), 32'(mbusy));
            chk("rnd m0_ready", 32'(m0_if.ready), 32'((done || abt) && cur == 0));
            chk("rnd m1_ready", 32'(m1_if.ready), 32'((done || abt) && cur == 1));
            chk("rnd err", 32'(err), 32'(merr));
            chk("rnd err_id", 32'(err_id), 32'(meid));
            if (mbusy) begin
                chk("rnd owner", 32'(owner), 32'(cur));
                chk("rnd s_addr", s_if.addr, ta[cur]);
                chk("rnd s_wdata", s_if.wdata, td[cur]);
                chk("rnd s_wstrb", 32'(s_if.wstrb), 32'(tw[cur]));
                chk("rnd m0_rdata", m0_if.rdata, abt ? 32'h0 : srd_r);
                chk("rnd m1_rdata", m1_if.rdata, abt ? 32'h0 : srd_r);
            end else begin
                chk("rnd idle s_wstrb", 32'(s_if.wstrb), 32'd0);
            end
            if (abt) begin
                merr = 1'b1;
                meid = 1'(cur);
            end else if (clr_r) begin
                merr = 1'b0;
            end
            if (done || abt) begin
                pend[cur] = 1'b0;
                last = cur;
                mbusy = 1'b0;
            end else if (mbusy) begin
                bc++;
            end else if (pend[0] || pend[1]) begin
                cur = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                mbusy = 1'b1;
                bc = 1;
                lat = int'($urandom_range(1, 6));
            end
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
